kmeans_iter_ctrl: RTL and testbench

//  Top-level sequencer for the k-means engine. It owns the 4096x16 single-port sample SRAM
//  (address and write-enable) and runs the phases in order: load samples, scan them to the

---
 rtl/kmeans_iter_ctrl.sv | 163 ++++++++++++++++
 tb/tb_kmeans_iter_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_iter_ctrl.sv
// kmeans_iter_ctrl: phase sequencer for the k-means engine.
// Owns the sample SRAM port and steps load -> scan -> update -> check -> output.
module kmeans_iter_ctrl #(
  parameter int DATA_SIZE = 4096,
  parameter int ADDR_W    = 12,
  parameter int MAX_ITER  = 64,
  parameter int ITER_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we_b,
  output logic              scan_valid,
  output logic              scan_last,
  output logic              upd_start,
  input  logic              upd_done,
  input  logic              converged,
  output logic              out_start,
  input  logic              out_done,
  output logic              busy,
  output logic [ITER_W-1:0] iter_count,
  output logic              timeout
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    DRAIN,
    UPDATE,
    CHECK,
    OUTPUT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_SIZE - 1);
  localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   wcnt;
  logic [ADDR_W-1:0]   wcnt_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                we_b_nxt;
  logic                scan_valid_nxt;
  logic                scan_last_nxt;
  logic                upd_start_nxt;
  logic                out_start_nxt;
  logic [ITER_W-1:0]   iter_nxt;
  logic                timeout_nxt;
  logic                load_done;
  logic                iter_at_max;
  logic                check_exit;

  // The final load write is the cycle presenting a write to the last address.
  assign load_done   = !mem_we_b && (mem_addr == LAST_ADDR);
  assign iter_at_max = (iter_count == ITER_MAX);
  assign check_exit  = converged || iter_at_max;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wcnt       <= '0;
      mem_addr   <= '0;
      mem_we_b   <= 1'b1;
      scan_valid <= 1'b0;
      scan_last  <= 1'b0;
      upd_start  <= 1'b0;
      out_start  <= 1'b0;
      iter_count <= '0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      wcnt       <= wcnt_nxt;
      mem_addr   <= addr_nxt;
      mem_we_b   <= we_b_nxt;
      scan_valid <= scan_valid_nxt;
      scan_last  <= scan_last_nxt;
      upd_start  <= upd_start_nxt;
      out_start  <= out_start_nxt;
      iter_count <= iter_nxt;
      timeout    <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = LOAD;
      LOAD:    if (load_done) state_nxt = SCAN;
      SCAN:    if (mem_addr == LAST_ADDR) state_nxt = DRAIN;
      DRAIN:   state_nxt = UPDATE;
      UPDATE:  if (upd_done) state_nxt = CHECK;
      CHECK:   state_nxt = check_exit ? OUTPUT : SCAN;
      OUTPUT:  if (out_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wcnt_nxt       = wcnt;
    addr_nxt       = mem_addr;
    we_b_nxt       = 1'b1;
    scan_valid_nxt = 1'b0;
    scan_last_nxt  = 1'b0;
    upd_start_nxt  = 1'b0;
    out_start_nxt  = 1'b0;
    iter_nxt       = iter_count;
    timeout_nxt    = timeout;
    case (state)
      IDLE: begin
        if (in_valid) begin
          addr_nxt    = '0;
          we_b_nxt    = 1'b0;
          wcnt_nxt    = ADDR_W'(1);
          iter_nxt    = '0;
          timeout_nxt = 1'b0;
        end
      end
      // During a pause the pending write address is presented as a harmless read.
      LOAD: begin
        if (load_done) begin
          addr_nxt = '0;
        end else begin
          addr_nxt = wcnt;
          if (in_valid) begin
            we_b_nxt = 1'b0;
            wcnt_nxt = wcnt + ADDR_W'(1);
          end
        end
      end
      SCAN: begin
        scan_valid_nxt = 1'b1;
        scan_last_nxt  = (mem_addr == LAST_ADDR);
        addr_nxt       = mem_addr + ADDR_W'(1);
      end
      DRAIN: begin
        upd_start_nxt = 1'b1;
      end
      UPDATE: begin
        if (upd_done && !iter_at_max) begin
          iter_nxt = iter_count + ITER_W'(1);
        end
      end
      CHECK: begin
        if (check_exit) begin
          out_start_nxt = 1'b1;
          if (!converged) begin
            timeout_nxt = 1'b1;
          end
        end else begin
          addr_nxt = '0;
        end
      end
      OUTPUT: begin
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Randomized bench for kmeans_iter_ctrl; expectations come from a frame-level model
// (words written in order, fixed-length scan passes, pass count from convergence/limit).
module tb_kmeans_iter_ctrl;

  localparam int DS = 8;
  localparam int AW = 3;
  localparam int MI = 3;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [AW-1:0] mem_addr;
  logic          mem_we_b;
  logic          scan_valid;
  logic          scan_last;
  logic          upd_start;
  logic          upd_done;
  logic          converged;
  logic          out_start;
  logic          out_done;
  logic          busy;
  logic [IW-1:0] iter_count;
  logic          timeout;

  int checks   = 0;
  int failures = 0;
  int g_gaps[DS];
  int g_upd[MI];

  kmeans_iter_ctrl #(
    .DATA_SIZE(DS),
    .ADDR_W   (AW),
    .MAX_ITER (MI),
    .ITER_W   (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .mem_addr  (mem_addr),
    .mem_we_b  (mem_we_b),
    .scan_valid(scan_valid),
    .scan_last (scan_last),
    .upd_start (upd_start),
    .upd_done  (upd_done),
    .converged (converged),
    .out_start (out_start),
    .out_done  (out_done),
    .busy      (busy),
    .iter_count(iter_count),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_strays(input bit strays, input logic tie);
    if (strays) begin
      in_valid  = 1'($urandom_range(0, 1));
      upd_done  = 1'($urandom_range(0, 1));
      out_done  = 1'($urandom_range(0, 1));
      converged = 1'($urandom_range(0, 1));
    end else begin
      in_valid  = 1'b0;
      upd_done  = 1'b0;
      out_done  = 1'b0;
      converged = tie;
    end
  endtask

  task automatic check_idle(input string name);
    logic [AW+7+IW:0] act;
    logic [AW+7+IW:0] req;
    act = {mem_addr, mem_we_b, scan_valid, scan_last, upd_start, out_start, busy, iter_count, timeout};
    req = {{AW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {IW{1'b0}}, 1'b0};
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: {addr,we_b,sv,sl,us,os,busy,iter,to}=%b required %b", name, act, req);
    end
  endtask

  // One full frame: load with g_gaps pauses, passes with g_upd delays, then output.
  task automatic run_frame(input int conv_pass, input int out_delay, input bit strays);
    int np;
    bit exp_to;
    logic tie;
    logic [AW+4:0] act;
    logic [AW+4:0] req;
    np     = (conv_pass >= 1 && conv_pass <= MI) ? conv_pass : MI;
    exp_to = !(conv_pass >= 1 && conv_pass <= MI);
    tie    = (conv_pass == 1);
    upd_done  = 1'b0;
    out_done  = 1'b0;
    converged = tie;
    for (int k = 0; k < DS; k++) begin
      in_valid = 1'b1;
      step();
      checks++;
      if (mem_we_b !== 1'b0 || mem_addr !== AW'(k) || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL load_write k=%0d: we_b=%b addr=%0d busy=%b, required we_b=0 addr=%0d busy=1",
                 k, mem_we_b, mem_addr, busy, k);
      end
      if (k == 0) begin
        checks++;
        if (iter_count !== '0 || timeout !== 1'b0) begin
          failures++;
          $display("[TB] FAIL frame_clear: iter=%0d timeout=%b, required 0 0", iter_count, timeout);
        end
      end
      if (k < DS - 1) begin
        for (int g = 0; g < g_gaps[k]; g++) begin
          in_valid = 1'b0;
          step();
          checks++;
          if (mem_we_b !== 1'b1 || mem_addr !== AW'(k + 1)) begin
            failures++;
            $display("[TB] FAIL load_gap k=%0d: we_b=%b addr=%0d, required we_b=1 addr=%0d",
                     k, mem_we_b, mem_addr, k + 1);
          end
        end
      end
    end
    in_valid = strays ? 1'($urandom_range(0, 1)) : 1'b0;
    step();
    for (int p = 1; p <= np; p++) begin
      for (int i = 0; i < DS; i++) begin
        act = {mem_addr, mem_we_b, scan_valid, scan_last, upd_start, out_start};
        req = {AW'(i), 1'b1, (i != 0), 1'b0, 1'b0, 1'b0};
        checks++;
        if (act !== req || busy !== 1'b1) begin
          failures++;
          $display("[TB] FAIL scan p=%0d i=%0d: {addr,we_b,sv,sl,us,os}=%b busy=%b, required %b busy=1",
                   p, i, act, busy, req);
        end
        drive_strays(strays, tie);
        step();
      end
      checks++;
      if (scan_valid !== 1'b1 || scan_last !== 1'b1 || upd_start !== 1'b0) begin
        failures++;
        $display("[TB] FAIL drain p=%0d: sv=%b sl=%b us=%b, required 1 1 0", p, scan_valid, scan_last, upd_start);
      end
      drive_strays(strays, tie);
      step();
      for (int w = 0; w <= g_upd[p-1]; w++) begin
        checks++;
        if (upd_start !== (w == 0) || scan_valid !== 1'b0 || scan_last !== 1'b0 || iter_count !== IW'(p - 1)) begin
          failures++;
          $display("[TB] FAIL update p=%0d w=%0d: us=%b sv=%b sl=%b iter=%0d, required us=%b sv=0 sl=0 iter=%0d",
                   p, w, upd_start, scan_valid, scan_last, iter_count, (w == 0), p - 1);
        end
        drive_strays(strays, tie);
        upd_done = (w == g_upd[p-1]);
        step();
      end
      checks++;
      if (iter_count !== IW'(p) || upd_start !== 1'b0 || out_start !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL check_state p=%0d: iter=%0d us=%b os=%b busy=%b, required iter=%0d 0 0 1",
                 p, iter_count, upd_start, out_start, busy, p);
      end
      drive_strays(strays, tie);
      converged = (p == conv_pass);
      step();
    end
    checks++;
    if (out_start !== 1'b1 || timeout !== exp_to || iter_count !== IW'(np)) begin
      failures++;
      $display("[TB] FAIL output_entry: os=%b timeout=%b iter=%0d, required os=1 timeout=%b iter=%0d",
               out_start, timeout, iter_count, exp_to, np);
    end
    for (int w = 0; w <= out_delay; w++) begin
      checks++;
      if (out_start !== (w == 0) || busy !== 1'b1 || scan_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL output_wait w=%0d: os=%b busy=%b sv=%b, required os=%b busy=1 sv=0",
                 w, out_start, busy, scan_valid, (w == 0));
      end
      drive_strays(strays, tie);
      out_done = (w == out_delay);
      step();
    end
    in_valid  = 1'b0;
    upd_done  = 1'b0;
    out_done  = 1'b0;
    converged = 1'b0;
    checks++;
    if (busy !== 1'b0 || timeout !== exp_to || iter_count !== IW'(np) || out_start !== 1'b0) begin
      failures++;
      $display("[TB] FAIL frame_end: busy=%b timeout=%b iter=%0d os=%b, required busy=0 timeout=%b iter=%0d os=0",
               busy, timeout, iter_count, out_start, exp_to, np);
    end
  endtask

  task automatic set_plain(input int upd_delay);
    for (int k = 0; k < DS; k++) g_gaps[k] = 0;
    for (int p = 0; p < MI; p++) g_upd[p] = upd_delay;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    upd_done = 1'b0;
    out_done = 1'b0;
    converged = 1'b0;
    step();
    step();
    check_idle("reset_initial");
    rst = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < DS; k++) step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (busy !== 1'b1 || mem_addr !== AW'(3) || scan_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pre_reset_scan: busy=%b addr=%0d sv=%b, required 1 3 1", busy, mem_addr, scan_valid);
    end
    rst = 1'b1;
    step();
    check_idle("reset_mid_scan_1");
    step();
    check_idle("reset_mid_scan_2");
    rst = 1'b0;
    step();
    check_idle("reset_released");
  endtask

  task automatic test_load_scan();
    set_plain(2);
    g_gaps[3] = 2;
    run_frame(1, 1, 1'b0);
  endtask

  task automatic test_timeout();
    set_plain(1);
    run_frame(0, 0, 1'b0);
    set_plain(0);
    run_frame(2, 0, 1'b0);
  endtask

  task automatic test_simultaneous();
    set_plain(0);
    run_frame(1, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < DS; k++) g_gaps[k] = int'($urandom_range(0, 2));
      for (int p = 0; p < MI; p++) g_upd[p] = int'($urandom_range(0, 3));
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_load_scan();
    test_timeout();
    test_simultaneous();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
